// File: rtl/pipe_ctrl_pkg.sv
// Shared forwarding encodings, scoreboard slot records and the register-match
// helper used by the pipeline hazard controller and its forwarding units.
package pipe_ctrl_pkg;

  localparam int REG_AW = 5;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef logic [REG_AW-1:0] reg_addr_t;

  typedef struct packed {
    logic      valid;
    reg_addr_t rd;
    logic      we;
    logic      load;
    reg_addr_t rs1;
    reg_addr_t rs2;
    logic      rs1_used;
    logic      rs2_used;
  } ex_slot_t;

  typedef struct packed {
    logic      valid;
    reg_addr_t rd;
    logic      we;
    logic      load;
  } mem_slot_t;

  typedef struct packed {
    logic      valid;
    reg_addr_t rd;
    logic      we;
  } wb_slot_t;

  // x0 is hardwired zero, so a write to it can never feed a consumer.
  function automatic logic slot_writes(input logic valid, input logic we,
                                       input reg_addr_t rd, input reg_addr_t r);
    return valid & we & (rd == r) & (r != '0);
  endfunction

endpackage

// File: rtl/hazard_fwd_unit.sv
// Combinational forwarding select for one EX source operand; zero latency.
// The youngest producer (MEM) wins over WB; a load still in MEM is never a source.
module hazard_fwd_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int FWD_EN = 1
) (
  input  reg_addr_t  i_rs,
  input  logic       i_rs_used,
  input  mem_slot_t  i_mem,
  input  wb_slot_t   i_wb,
  output logic [1:0] o_sel
);

  logic w_mem_hit;
  logic w_wb_hit;

  assign w_mem_hit = slot_writes(i_mem.valid, i_mem.we, i_mem.rd, i_rs) & ~i_mem.load;
  assign w_wb_hit  = slot_writes(i_wb.valid, i_wb.we, i_wb.rd, i_rs);

  always_comb begin
    o_sel = FWD_REG;
    if ((FWD_EN != 0) && i_rs_used) begin
      if (w_mem_hit) begin
        o_sel = FWD_MEM;
      end else if (w_wb_hit) begin
        o_sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// 5-stage pipeline hazard controller: stall/flush/forward outputs are combinational
// from the EX/MEM/WB shadow slots and the current ID inputs; counters are registered.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW = pipe_ctrl_pkg::REG_AW,
  parameter int CNT_W  = 8,
  parameter int FWD_EN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_is_load,
  input  logic              ex_branch_taken,
  output logic              pc_write_en,
  output logic              if_id_write_en,
  output logic              if_id_flush,
  output logic              id_ex_bubble,
  output logic [1:0]        fwd_sel_1,
  output logic [1:0]        fwd_sel_2,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  ex_slot_t         r_ex;
  mem_slot_t        r_mem;
  wb_slot_t         r_wb;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  ex_slot_t   w_ex_next;
  logic       w_ex_hit1, w_ex_hit2;
  logic       w_mem_hit1, w_mem_hit2;
  logic       w_raw, w_stall, w_flush;
  logic       w_mem_load_hit;
  logic [1:0] w_fwd1, w_fwd2;

  assign w_ex_hit1  = id_rs1_used & slot_writes(r_ex.valid, r_ex.we, r_ex.rd, id_rs1);
  assign w_ex_hit2  = id_rs2_used & slot_writes(r_ex.valid, r_ex.we, r_ex.rd, id_rs2);
  assign w_mem_hit1 = id_rs1_used & slot_writes(r_mem.valid, r_mem.we, r_mem.rd, id_rs1);
  assign w_mem_hit2 = id_rs2_used & slot_writes(r_mem.valid, r_mem.we, r_mem.rd, id_rs2);

  // Without forwarding, any producer still in EX or MEM blocks the reader; WB
  // writes before the register file is read, so it never blocks.
  assign w_raw = (FWD_EN != 0) ? (r_ex.load & (w_ex_hit1 | w_ex_hit2))
                               : (w_ex_hit1 | w_ex_hit2 | w_mem_hit1 | w_mem_hit2);

  assign w_flush = ex_branch_taken;
  assign w_stall = id_valid & w_raw & ~w_flush;

  hazard_fwd_unit #(.FWD_EN(FWD_EN)) u_fwd1 (
    .i_rs      (r_ex.rs1),
    .i_rs_used (r_ex.rs1_used),
    .i_mem     (r_mem),
    .i_wb      (r_wb),
    .o_sel     (w_fwd1)
  );

  hazard_fwd_unit #(.FWD_EN(FWD_EN)) u_fwd2 (
    .i_rs      (r_ex.rs2),
    .i_rs_used (r_ex.rs2_used),
    .i_mem     (r_mem),
    .i_wb      (r_wb),
    .o_sel     (w_fwd2)
  );

  always_comb begin
    pc_write_en    = 1'b0;
    if_id_write_en = 1'b0;
    if_id_flush    = 1'b1;
    id_ex_bubble   = 1'b1;
    fwd_sel_1      = FWD_REG;
    fwd_sel_2      = FWD_REG;
    if (rst_n) begin
      pc_write_en    = ~w_stall;
      if_id_write_en = ~w_stall;
      if_id_flush    = w_flush;
      id_ex_bubble   = w_stall | w_flush;
      fwd_sel_1      = w_fwd1;
      fwd_sel_2      = w_fwd2;
    end
  end

  always_comb begin
    w_ex_next = '0;
    if (id_valid && !id_ex_bubble) begin
      w_ex_next.valid    = 1'b1;
      w_ex_next.rd       = id_rd;
      w_ex_next.we       = id_reg_write;
      w_ex_next.load     = id_is_load;
      w_ex_next.rs1      = id_rs1;
      w_ex_next.rs2      = id_rs2;
      w_ex_next.rs1_used = id_rs1_used;
      w_ex_next.rs2_used = id_rs2_used;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ex        <= '0;
      r_mem       <= '0;
      r_wb        <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_ex        <= w_ex_next;
      r_mem.valid <= r_ex.valid;
      r_mem.rd    <= r_ex.rd;
      r_mem.we    <= r_ex.we;
      r_mem.load  <= r_ex.load;
      r_wb.valid  <= r_mem.valid;
      r_wb.rd     <= r_mem.rd;
      r_wb.we     <= r_mem.we;
      if (w_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (w_flush && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

  // The load-use stall must keep a consumer out of EX while its load sits in MEM.
  assign w_mem_load_hit = r_mem.load &
      ((r_ex.rs1_used & slot_writes(r_mem.valid, r_mem.we, r_mem.rd, r_ex.rs1)) |
       (r_ex.rs2_used & slot_writes(r_mem.valid, r_mem.we, r_mem.rd, r_ex.rs2)));

  a_no_mem_load_fwd: assert property (@(posedge clk) disable iff (!rst_n)
                                      !(r_ex.valid && w_mem_load_hit));

endmodule
